// File: rtl/reg_dump_uart_tx_pkg.sv
// Shared definitions for the register-dump UART transmitter.
//   reg_dump_state_t   : sequencer state encoding
//   FRAME_BYTES        : bytes per dump frame (sync + PC + 32 registers)
//   UART_BITS_PER_BYTE : start + 8 data + stop
//   word_byte()        : big-endian byte select from a 32-bit word
package reg_dump_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_SYNC = 3'd1,
    ST_SEND_PC   = 3'd2,
    ST_SEL_REG   = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_SEND_REG  = 3'd5,
    ST_FINISH    = 3'd6
  } reg_dump_state_t;

  localparam int FRAME_BYTES        = 133;
  localparam int UART_BITS_PER_BYTE = 10;
  localparam int REG_COUNT          = 32;

  // Byte 0 is the most significant byte, so words go out MSB first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_dump_uart_tx_uart.sv
// 8N1 byte transmitter with a valid/ready input handshake.
//   CLOCK, Reset : board clock, async active-low reset
//   data, valid  : byte to send and its request
//   ready        : high when a new byte can be accepted
//   Tx           : serial line, idles high
// ready is also raised during the last cycle of the stop bit so that a
// waiting byte is accepted on the very edge the stop bit ends, giving
// back-to-back bytes with no idle gap.
module uart_tx_byte
  import reg_dump_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       Tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BIT_LAST = 4'(UART_BITS_PER_BYTE - 1);

  logic          active_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    bit_idx_r;
  logic [8:0]    shift_r;
  logic          tx_r;
  logic          last_tick_s;
  logic          accept_s;

  assign last_tick_s = active_r && (cnt_r == CNT_LAST) && (bit_idx_r == BIT_LAST);
  assign ready       = !active_r || last_tick_s;
  assign accept_s    = valid && ready;
  assign Tx          = tx_r;

  // Bit-period counter, bit index and shift register; shift_r holds the
  // data bits still to send with the stop bit shifted in behind them.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      active_r  <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      bit_idx_r <= 4'd0;
      shift_r   <= 9'h000;
      tx_r      <= 1'b1;
    end else if (accept_s) begin
      active_r  <= 1'b1;
      cnt_r     <= {CW{1'b0}};
      bit_idx_r <= 4'd0;
      shift_r   <= {1'b1, data};
      tx_r      <= 1'b0;
    end else if (active_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= {CW{1'b0}};
        if (bit_idx_r == BIT_LAST) begin
          active_r <= 1'b0;
          tx_r     <= 1'b1;
        end else begin
          bit_idx_r <= bit_idx_r + 4'd1;
          tx_r      <= shift_r[0];
          shift_r   <= {1'b1, shift_r[8:1]};
        end
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      tx_r <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Register-file dump over UART. On Start it latches PC, then walks Regin
// through x0..x31, captures each Regout word and streams the frame
// SYNC_BYTE, PC[4], x0[4]..x31[4] (MSB first) as 8N1.
//   CLOCK, Reset : board clock, async active-low reset
//   Start        : dump request, sampled only when idle
//   PC, Regout   : CPU program counter and register-read data
//   Regin        : register index driven to the CPU
//   Tx           : UART line
//   Busy, Done   : frame in progress / one-cycle end-of-frame pulse
module reg_dump_uart_tx
  import reg_dump_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT  = 434,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] PC,
  input  logic [31:0] Regout,
  output logic [4:0]  Regin,
  output logic        Tx,
  output logic        Busy,
  output logic        Done
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]    LAST_REG    = 5'(REG_COUNT - 1);

  reg_dump_state_t state_r, state_s;
  logic [4:0]    idx_r, idx_s;
  logic [2:0]    byte_cnt_r, byte_cnt_s;
  logic [SW-1:0] settle_cnt_r, settle_cnt_s;
  logic [31:0]   pc_r;
  logic [31:0]   word_r;
  logic [4:0]    regin_r;
  logic          busy_r;
  logic          done_r;
  logic          tx_valid_s;
  logic [7:0]    tx_data_s;
  logic          tx_ready_s;
  logic          accept_s;

  assign accept_s = tx_valid_s && tx_ready_s;
  assign Regin    = regin_r;
  assign Busy     = busy_r;
  assign Done     = done_r;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .CLOCK (CLOCK),
    .Reset (Reset),
    .data  (tx_data_s),
    .valid (tx_valid_s),
    .ready (tx_ready_s),
    .Tx    (Tx)
  );

  // Sequencer next-state and byte-request logic. The 4th byte of a word is
  // handed over before the next register is selected, so selection and
  // settling overlap that byte's shifting. After x31 the sequencer stays in
  // SEND_REG with byte_cnt=4 until the transmitter drains.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    byte_cnt_s   = byte_cnt_r;
    settle_cnt_s = settle_cnt_r;
    tx_valid_s   = 1'b0;
    tx_data_s    = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_s = ST_SEND_SYNC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND_SYNC: begin
        tx_valid_s = 1'b1;
        tx_data_s  = SYNC_BYTE;
        if (accept_s) begin
          state_s    = ST_SEND_PC;
          byte_cnt_s = 3'd0;
        end else begin
          state_s = ST_SEND_SYNC;
        end
      end
      ST_SEND_PC: begin
        tx_valid_s = 1'b1;
        tx_data_s  = word_byte(pc_r, byte_cnt_r[1:0]);
        if (accept_s && (byte_cnt_r == 3'd3)) begin
          state_s    = ST_SEL_REG;
          idx_s      = 5'd0;
          byte_cnt_s = 3'd0;
        end else if (accept_s) begin
          byte_cnt_s = byte_cnt_r + 3'd1;
        end else begin
          byte_cnt_s = byte_cnt_r;
        end
      end
      ST_SEL_REG: begin
        state_s      = ST_SETTLE;
        settle_cnt_s = {SW{1'b0}};
      end
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          state_s    = ST_SEND_REG;
          byte_cnt_s = 3'd0;
        end else begin
          settle_cnt_s = settle_cnt_r + SW'(1);
        end
      end
      ST_SEND_REG: begin
        if (byte_cnt_r == 3'd4) begin
          if (tx_ready_s) begin
            state_s = ST_FINISH;
          end else begin
            state_s = ST_SEND_REG;
          end
        end else begin
          tx_valid_s = 1'b1;
          tx_data_s  = word_byte(word_r, byte_cnt_r[1:0]);
          if (accept_s && (byte_cnt_r == 3'd3)) begin
            if (idx_r == LAST_REG) begin
              byte_cnt_s = 3'd4;
            end else begin
              state_s    = ST_SEL_REG;
              idx_s      = idx_r + 5'd1;
              byte_cnt_s = 3'd0;
            end
          end else if (accept_s) begin
            byte_cnt_s = byte_cnt_r + 3'd1;
          end else begin
            byte_cnt_s = byte_cnt_r;
          end
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
        idx_s   = 5'd0;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters, captures and registered outputs.
  // Regin is updated on entry to SEL_REG so the settle window starts as
  // early as possible.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= 5'd0;
      byte_cnt_r   <= 3'd0;
      settle_cnt_r <= {SW{1'b0}};
      pc_r         <= 32'h0000_0000;
      word_r       <= 32'h0000_0000;
      regin_r      <= 5'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      byte_cnt_r   <= byte_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      if ((state_r == ST_IDLE) && Start) begin
        pc_r <= PC;
      end
      if ((state_r == ST_SETTLE) && (settle_cnt_r == SETTLE_LAST)) begin
        word_r <= Regout;
      end
      if (state_s == ST_SEL_REG) begin
        regin_r <= idx_s;
      end else if (state_s == ST_FINISH) begin
        regin_r <= 5'd0;
      end
      busy_r <= (state_s != ST_IDLE) && (state_s != ST_FINISH);
      done_r <= (state_s == ST_FINISH);
    end
  end

endmodule
